// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx byte-port arbiter.
// The round-robin pick is written once here so the arbiter sub-module
// (and any other block that needs the same policy) agree bit-for-bit.
package uart_arb_pkg;

    // Arbiter owner phases: no owner, emitting the source-ID header, passing bytes through.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Widest requester vector the helper understands, and the index width it needs.
    localparam int MAX_REQ = 8;
    localparam int MAX_IW  = 3;

    typedef struct packed {
        logic [MAX_IW-1:0] idx;
        logic              found;
    } rr_pick_t;

    // First set bit of valid[n-1:0], scanning ptr, ptr+1, ... modulo n.
    // Scanning upward and keeping only the first hit gives the nearest
    // requester at or after the pointer.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        ptr,
        input int unsigned        n
    );
        rr_pick_t    r;
        int unsigned j;
        r.idx   = '0;
        r.found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = (ptr + k) % n;
                if (!r.found && valid[MAX_IW'(j)]) begin
                    r.found = 1'b1;
                    r.idx   = MAX_IW'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: given a request vector and a priority
// pointer, returns the nearest requester at or after the pointer.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    rr_pick_t pick;

    // Evaluate the shared pick function on the zero-extended request vector.
    always_comb begin
        pick = rr_pick(MAX_REQ'(valid), 32'(ptr), N);
    end

    assign idx   = IW'(pick.idx);
    assign found = pick.found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte port among N_REQ packet sources.
// Round-robin grant; the owner keeps the port until its last byte is taken
// or until it goes quiet for TIMEOUT cycles. Each packet may be preceded by
// a one-byte header HDR_BASE + source id.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         N_REQ     = 4,
    parameter int         HEADER_EN = 1,
    parameter logic [7:0] HDR_BASE  = 8'hA0,
    parameter int         TIMEOUT   = 255,
    localparam int        IW        = $clog2(N_REQ),
    localparam int        CW        = $clog2(TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IW-1:0]      grant_id,
    output logic               busy,
    output logic               timeout_evt
);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]    hdr_q, hdr_d;
    logic          timeout_evt_q, timeout_evt_d;

    logic [7:0]    req_bytes [N_REQ];
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic [IW-1:0] next_ptr;
    logic          own_valid;
    logic          own_last;
    logic [7:0]    own_data;
    logic          own_xfer;

    // Per-requester byte lanes and ready strobes; only the owner in DATA sees out_ready.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign req_bytes[gi] = req_data[8*gi +: 8];
            assign req_ready[gi] = (state_q == DATA) && (grant_q == IW'(gi)) && out_ready;
        end
    endgenerate

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign own_valid = req_valid[grant_q];
    assign own_last  = req_last[grant_q];
    assign own_data  = req_bytes[grant_q];
    assign own_xfer  = (state_q == DATA) && own_valid && out_ready;

    // Priority moves to the requester after the one just released, wrapping at N_REQ.
    assign next_ptr = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_q;
    assign timeout_evt = timeout_evt_q;

    // Output mux: registered header byte in HDR, straight pass-through of the owner in DATA.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        case (state_q)
            HDR: begin
                out_valid = 1'b1;
                out_data  = hdr_q;
            end
            DATA: begin
                out_valid = own_valid;
                out_data  = own_data;
            end
            default: begin
            end
        endcase
    end

    // Next-state logic: arbitration, header hand-off, end-of-packet and quiet-owner revocation.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        idle_cnt_d    = idle_cnt_q;
        hdr_d         = hdr_q;
        timeout_evt_d = 1'b0;
        case (state_q)
            IDLE: begin
                idle_cnt_d = '0;
                if (pick_found) begin
                    grant_d = pick_idx;
                    hdr_d   = HDR_BASE + 8'(pick_idx);
                    state_d = (HEADER_EN != 0) ? HDR : DATA;
                end
            end
            HDR: begin
                if (out_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (own_xfer) begin
                    idle_cnt_d = '0;
                    if (own_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else if (!own_valid) begin
                    // The TIMEOUT-th consecutive quiet cycle releases the port; nothing
                    // is pending, so no byte is lost. The counter never passes TIMEOUT-1.
                    if (idle_cnt_q >= CW'(TIMEOUT - 1)) begin
                        state_d       = IDLE;
                        rr_ptr_d      = next_ptr;
                        idle_cnt_d    = '0;
                        timeout_evt_d = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
                // Owner valid but downstream stalled: back-pressure, counter holds.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and bookkeeping registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            idle_cnt_q    <= '0;
            hdr_q         <= 8'h00;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            idle_cnt_q    <= idle_cnt_d;
            hdr_q         <= hdr_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: N_REQ=4, HEADER_EN=1, HDR_BASE=A0, TIMEOUT=8.
// Sources are byte queues; the expected output stream (header + bytes, in
// hand-computed grant order) is compared on every accepted byte, and
// per-cycle rules (owner-only ready, pass-through, hold under stall) are checked.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last  = '0;
    logic [3:0]  req_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_evt;

    uart_tx_arbiter #(
        .N_REQ     (N),
        .HEADER_EN (1),
        .HDR_BASE  (8'hA0),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] src_q [N][$];
    logic [7:0] exp_q [$];
    int         glog [$];
    int         force_stall  = 0;
    bit         rand_stall   = 0;
    logic [3:0] rdy_seen     = '0;
    int         tevt_count   = 0;
    int         stall_cycles = 0;
    int         cyc          = 0;
    int         cyc_55       = -1;
    int         cyc_tevt     = -1;
    bit         seen_81      = 0;
    bit         seen_90      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model of the output stream: a granted packet is its header byte then its bytes.
    task automatic load_pkt(input int src, input int n, input logic [31:0] bytes, input bit is_last);
        logic [8:0] e;
        exp_q.push_back(8'hA0 + 8'(src));
        for (int k = 0; k < n; k++) begin
            e = {(is_last && (k == n - 1)), bytes[8*k +: 8]};
            src_q[src].push_back(e);
            exp_q.push_back(bytes[8*k +: 8]);
        end
    endtask

    function automatic bit srcs_empty();
        bit r = 1'b1;
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_done(input string name, input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && srcs_empty() && !busy) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_drain actual=%0d_pending required=0", name, exp_q.size());
        end
    endtask

    // Grant order as 4-bit ids packed low-first.
    task automatic check_glog(input string name, input int n, input logic [31:0] ids);
        check({name, "_ngrants"}, 32'(glog.size()), 32'(n));
        for (int k = 0; k < n && k < glog.size(); k++)
            check({name, "_grant"}, 32'(glog[k]), 32'(ids[4*k +: 4]));
    endtask

    task automatic wait_flag81(input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(posedge clk);
            #2;
            ok = seen_81;
        end
        check("wait_81", 32'(ok), 32'd1);
    endtask

    task automatic wait_flag90(input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(posedge clk);
            #2;
            ok = seen_90;
        end
        check("wait_90", 32'(ok), 32'd1);
    endtask

    // Source and sink driver: pops accepted bytes, presents queue heads, drives out_ready.
    initial begin
        logic [3:0] xfer_src;
        forever begin
            @(negedge clk);
            xfer_src = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int i = 0; i < N; i++)
                    if (xfer_src[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src_q[i][0][7:0];
                    req_last[i]        = src_q[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
            if (force_stall > 0) begin
                out_ready = 1'b0;
                force_stall--;
            end else if (rand_stall) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Compare process: every accepted byte against the model stream, plus per-cycle rules.
    initial begin
        logic       pv, pr, was_busy;
        logic [7:0] pd, e;
        pv = 1'b0; pr = 1'b0; pd = 8'h00; was_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pv = 1'b0;
                was_busy = 1'b0;
            end else begin
                if (busy && !was_busy) glog.push_back(int'(grant_id));
                was_busy = busy;
                rdy_seen |= req_ready;
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        check("rdy_owner", 32'({busy, grant_id == 2'(i), out_ready}), 32'h7);
                        if (req_valid[i])
                            check("rdy_pass", 32'({out_valid, out_data}), 32'({1'b1, req_data[8*i +: 8]}));
                    end
                end
                if (pv && !pr) check("hold", 32'({out_valid, out_data}), 32'({1'b1, pd}));
                if (out_valid && !out_ready) stall_cycles++;
                if (timeout_evt) begin
                    tevt_count++;
                    cyc_tevt = cyc;
                    check("evt_busy", 32'(busy), 32'd0);
                end
                if (out_valid && out_ready) begin
                    $display("xfer grant=%0d byte=%02h", grant_id, out_data);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte actual=%02h required=none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'(out_data), 32'(e));
                    end
                    if (out_data == 8'h55 && grant_id == 2'd1) cyc_55 = cyc;
                    if (out_data == 8'h81) seen_81 = 1'b1;
                    if (out_data == 8'h90) seen_90 = 1'b1;
                end
                pv = out_valid; pr = out_ready; pd = out_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_timeout_evt", 32'(timeout_evt), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: single source, header A1 then 11 22 33; only req_ready[1] ever rises.
        rdy_seen = '0;
        load_pkt(1, 3, 32'h00332211, 1'b1);
        wait_done("t1", 200);
        check("t1_ready_mask", 32'(rdy_seen), 32'h2);

        // Return pointer to 0 for the contention round.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // 2: all four contend; req0 has a second packet queued behind its first,
        // which must wait until after req3 (pointer wraps 3 -> 0).
        rand_stall = 1'b1;
        glog.delete();
        load_pkt(0, 2, 32'h0201, 1'b1);
        load_pkt(1, 2, 32'h1211, 1'b1);
        load_pkt(2, 2, 32'h2221, 1'b1);
        load_pkt(3, 2, 32'h3231, 1'b1);
        load_pkt(0, 2, 32'h0605, 1'b1);
        wait_done("t2", 600);
        check_glog("t2", 5, 32'h03210);

        // 3: req0 and req2 both continuously valid; pointer is 1, so 2,0,2,0.
        // req2's second packet is a single byte.
        glog.delete();
        load_pkt(2, 2, 32'h6160, 1'b1);
        load_pkt(0, 2, 32'h4140, 1'b1);
        load_pkt(2, 1, 32'h62, 1'b1);
        load_pkt(0, 2, 32'h4342, 1'b1);
        wait_done("t3", 600);
        check_glog("t3", 4, 32'h0202);

        // 4: req1 sends 55 without last then goes quiet; req2 waits.
        rand_stall = 1'b0;
        glog.delete();
        tevt_count = 0;
        load_pkt(1, 1, 32'h55, 1'b0);
        load_pkt(2, 2, 32'h7170, 1'b1);
        wait_done("t4a", 300);
        check("t4_timeouts", 32'(tevt_count), 32'd1);
        // Byte 55 accepted in cycle c; quiet cycles c+1..c+8; pulse visible in c+9.
        check("t4_timeout_gap", 32'(cyc_tevt - cyc_55), 32'(TO + 1));
        load_pkt(1, 1, 32'h56, 1'b1);
        wait_done("t4b", 200);
        check_glog("t4", 3, 32'h121);
        check("t4_timeouts_after", 32'(tevt_count), 32'd1);

        // 5: 20 stalled cycles mid-packet must not time out or disturb the stream.
        glog.delete();
        stall_cycles = 0;
        seen_81 = 1'b0;
        load_pkt(1, 4, 32'h84838281, 1'b1);
        wait_flag81(100);
        force_stall = 20;
        wait_done("t5", 300);
        check("t5_no_timeout", 32'(tevt_count), 32'd1);
        check("t5_stall_len", 32'(stall_cycles), 32'd20);
        check_glog("t5", 1, 32'h1);

        // 6: reset during req2's packet; outputs drop at once and the pointer returns to 0.
        glog.delete();
        seen_90 = 1'b0;
        load_pkt(2, 3, 32'h929190, 1'b1);
        wait_flag90(100);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        glog.delete();
        load_pkt(0, 1, 32'hB0, 1'b1);
        load_pkt(3, 1, 32'hC0, 1'b1);
        wait_done("t6", 200);
        check_glog("t6", 2, 32'h30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
